// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter.
// Stores to TXDATA queue bytes in a small FIFO; a serial engine sends them
// LSB first. STATUS reports {ovf, active, empty, full} for firmware polling.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0100,
    parameter int          CLKS_PER_BIT = 4,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        tx
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL_COUNT  = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0] BCNT_LAST   = BW'(CLKS_PER_BIT - 1);
    localparam logic [31:0]   STATUS_ADDR = BASE_ADDR + 32'd4;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_n;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wptr, rptr;
    logic [CW-1:0] count;
    logic          ovf;
    logic [BW-1:0] bcnt, bcnt_n;
    logic [2:0]    bidx, bidx_n;
    logic [7:0]    shift, shift_n;
    logic          tx_n;
    logic          sel_data, sel_stat, full, empty;
    logic          push_req, push, pop, bend;
    logic          unused_ok;

    // Only the low byte and the ovf-clear bit of the store data matter.
    assign unused_ok = &{1'b0, wd[31:8]};

    assign sel_data = (addr == BASE_ADDR);
    assign sel_stat = (addr == STATUS_ADDR);
    assign full     = (count == FULL_COUNT);
    assign empty    = (count == '0);
    assign bend     = (bcnt == BCNT_LAST);
    assign push_req = we && sel_data;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign push     = push_req && (!full || pop);

    // Load path: STATUS is visible combinationally, everything else reads zero.
    always_comb begin
        rd = '0;
        if (sel_stat) begin
            rd = {28'b0, ovf, (state != IDLE), empty, full};
        end
    end

    // FIFO storage; entries need no reset because count gates their use.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= wd[7:0];
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the depth.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow flag: set by a dropped store, cleared by STATUS bit 3.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ovf <= 1'b0;
        end else if (push_req && !push) begin
            ovf <= 1'b1;
        end else if (we && sel_stat && wd[3]) begin
            ovf <= 1'b0;
        end
    end

    // Serial engine registers, including the registered tx line.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            bcnt  <= '0;
            bidx  <= '0;
            shift <= '0;
            tx    <= 1'b1;
        end else begin
            state <= state_n;
            bcnt  <= bcnt_n;
            bidx  <= bidx_n;
            shift <= shift_n;
            tx    <= tx_n;
        end
    end

    // Next-state logic; pop uses the registered count, so a byte pushed this
    // cycle is not seen by the engine until the following cycle.
    always_comb begin
        state_n = state;
        bcnt_n  = bcnt;
        bidx_n  = bidx;
        shift_n = shift;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_n = mem[rptr];
                    bcnt_n  = '0;
                    state_n = START;
                end
            end
            START: begin
                if (bend) begin
                    bcnt_n  = '0;
                    bidx_n  = '0;
                    state_n = DATA;
                end else begin
                    bcnt_n = bcnt + 1'b1;
                end
            end
            DATA: begin
                if (bend) begin
                    bcnt_n  = '0;
                    shift_n = {1'b0, shift[7:1]};
                    if (bidx == 3'd7) begin
                        state_n = STOP;
                    end else begin
                        bidx_n = bidx + 1'b1;
                    end
                end else begin
                    bcnt_n = bcnt + 1'b1;
                end
            end
            STOP: begin
                if (bend) begin
                    bcnt_n = '0;
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_n = mem[rptr];
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    bcnt_n = bcnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
            default: tx_n = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: self-checking bench for mmio_uart_tx.
// Bytes expected on the line go into a scoreboard queue when stored; a line
// monitor rebuilds each 40-cycle frame and compares it against the queue head.
module tb_mmio_uart_tx;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wd = '0;
    logic [31:0] rd;
    logic        tx;

    int checkCount = 0;
    int passCount = 0;
    int cycle = 0;
    int frameCount = 0;
    logic [7:0] expQ[$];
    int starts[$];

    logic        monBusy = 1'b0;
    int          monCnt = 0;
    logic [39:0] monBits = '0;
    logic [7:0]  monExp;

    typedef struct {
        string       name;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rdAddr;
        logic [31:0] expRd;
        logic        queued;
    } vec_t;

    vec_t vecs[11];

    mmio_uart_tx #(
        .BASE_ADDR(32'h0000_0100),
        .CLKS_PER_BIT(4),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .we(we),
        .addr(addr),
        .wd(wd),
        .rd(rd),
        .tx(tx)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Rising-edge counter used to time stores and measure frame starts.
    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    // Ideal 8N1 waveform for one byte, four samples per bit.
    function automatic logic [39:0] expFrame(input logic [7:0] b);
        logic [39:0] f;
        int k;
        f = '0;
        for (int p = 0; p < 40; p++) begin
            k = p / 4;
            if (k == 0)      f[p] = 1'b0;
            else if (k == 9) f[p] = 1'b1;
            else             f[p] = b[k-1];
        end
        return f;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [31:0] d);
        we = w;
        addr = a;
        wd = d;
        tick();
        we = 1'b0;
    endtask

    task automatic readReg(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = rd;
    endtask

    // Line monitor: samples tx on falling edges, collects 40 samples from the
    // start bit and checks the whole frame against the scoreboard head.
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            monBusy = 1'b0;
            monCnt = 0;
        end else if (!monBusy) begin
            if (tx === 1'b0) begin
                monBusy = 1'b1;
                monBits = '0;
                monCnt = 1;
                starts.push_back(cycle);
            end
        end else begin
            monBits[monCnt] = tx;
            monCnt++;
            if (monCnt == 40) begin
                monBusy = 1'b0;
                frameCount++;
                if (expQ.size() == 0) begin
                    checkOutput("frame_unexpected", {24'b0, monBits}, {24'b0, 40'hFF_FFFF_FFFF});
                end else begin
                    monExp = expQ.pop_front();
                    checkOutput("frame_bits", {24'b0, monBits}, {24'b0, expFrame(monExp)});
                end
            end
        end
    end

    initial begin
        logic [31:0] r;
        int w;
        int e0;
        int fc0;
        int lows;

        vecs[0]  = '{"fill0",       1'b1, 32'h100, 32'h3C, 32'h104, 32'h0, 1'b1};
        vecs[1]  = '{"fill1",       1'b1, 32'h100, 32'hC3, 32'h104, 32'h4, 1'b1};
        vecs[2]  = '{"fill2",       1'b1, 32'h100, 32'h81, 32'h104, 32'h4, 1'b1};
        vecs[3]  = '{"fill3",       1'b1, 32'h100, 32'h7E, 32'h104, 32'h4, 1'b1};
        vecs[4]  = '{"fill_full",   1'b1, 32'h100, 32'h96, 32'h104, 32'h5, 1'b1};
        vecs[5]  = '{"overflow",    1'b1, 32'h100, 32'hE7, 32'h104, 32'hD, 1'b0};
        vecs[6]  = '{"ovf_keep",    1'b1, 32'h104, 32'hF7, 32'h104, 32'hD, 1'b0};
        vecs[7]  = '{"ovf_clear",   1'b1, 32'h104, 32'h08, 32'h104, 32'h5, 1'b0};
        vecs[8]  = '{"decode_108",  1'b1, 32'h108, 32'hA5, 32'h108, 32'h0, 1'b0};
        vecs[9]  = '{"txdata_read", 1'b1, 32'h101, 32'hA5, 32'h100, 32'h0, 1'b0};
        vecs[10] = '{"status_hold", 1'b0, 32'h000, 32'h00, 32'h104, 32'h5, 1'b0};

        // Reset state and quiet idle line.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_tx", {63'b0, tx}, 64'd1);
        readReg(32'h104, r);
        checkOutput("reset_status", {32'b0, r}, 64'h2);
        rst = 1'b1;
        lows = 0;
        repeat (20) begin
            tick();
            if (tx !== 1'b1) lows++;
        end
        checkOutput("idle_tx_low_count", lows, 0);

        // Single byte: latency, active flag and full frame shape.
        starts.delete();
        fc0 = frameCount;
        expQ.push_back(8'hA5);
        applyStimulus(1'b1, 32'h100, 32'hA5);
        w = cycle;
        readReg(32'h104, r);
        checkOutput("single_status_queued", {32'b0, r}, 64'h0);
        tick();
        readReg(32'h104, r);
        checkOutput("single_status_active", {32'b0, r}, 64'h6);
        while (cycle < w + 40) tick();
        readReg(32'h104, r);
        checkOutput("single_status_last_stop", {32'b0, r}, 64'h6);
        tick();
        readReg(32'h104, r);
        checkOutput("single_status_done", {32'b0, r}, 64'h2);
        tick();
        checkOutput("single_frame_count", frameCount - fc0, 1);
        if (starts.size() >= 1) checkOutput("single_start_latency", starts[0], w + 1);

        // Back-to-back frames from consecutive stores.
        repeat (5) tick();
        starts.delete();
        fc0 = frameCount;
        expQ.push_back(8'h55);
        applyStimulus(1'b1, 32'h100, 32'h55);
        w = cycle;
        expQ.push_back(8'h0F);
        applyStimulus(1'b1, 32'h100, 32'h0F);
        repeat (85) tick();
        checkOutput("b2b_frame_count", frameCount - fc0, 2);
        if (starts.size() >= 2) begin
            checkOutput("b2b_first_start", starts[0], w + 1);
            checkOutput("b2b_gap", starts[1] - starts[0], 40);
        end
        readReg(32'h104, r);
        checkOutput("b2b_status_done", {32'b0, r}, 64'h2);

        // Fill, overflow, ovf clear and address decode from the vector table.
        repeat (5) tick();
        fc0 = frameCount;
        e0 = 0;
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].queued) expQ.push_back(vecs[i].wd[7:0]);
            applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].wd);
            if (i == 0) e0 = cycle;
            readReg(vecs[i].rdAddr, r);
            checkOutput(vecs[i].name, {32'b0, r}, {32'b0, vecs[i].expRd});
        end

        // Store landing on the STOP-end edge of the first frame with a full FIFO.
        while (cycle < e0 + 40) tick();
        readReg(32'h104, r);
        checkOutput("full_before_stop_end", {32'b0, r}, 64'h5);
        expQ.push_back(8'h5A);
        applyStimulus(1'b1, 32'h100, 32'h5A);
        readReg(32'h104, r);
        checkOutput("push_pop_full", {32'b0, r}, 64'h5);
        repeat (215) tick();
        checkOutput("fill_frame_count", frameCount - fc0, 6);
        checkOutput("fill_queue_drained", expQ.size(), 0);
        readReg(32'h104, r);
        checkOutput("fill_status_done", {32'b0, r}, 64'h2);

        // Reset during the data bits of a frame with another byte queued.
        repeat (5) tick();
        fc0 = frameCount;
        applyStimulus(1'b1, 32'h100, 32'h00);
        w = cycle;
        applyStimulus(1'b1, 32'h100, 32'h66);
        while (cycle < w + 14) tick();
        checkOutput("tx_data_before_reset", {63'b0, tx}, 64'd0);
        readReg(32'h104, r);
        checkOutput("status_before_reset", {32'b0, r}, 64'h4);
        rst = 1'b0;
        tick();
        checkOutput("tx_after_reset", {63'b0, tx}, 64'd1);
        readReg(32'h104, r);
        checkOutput("status_after_reset", {32'b0, r}, 64'h2);
        rst = 1'b1;
        repeat (60) tick();
        checkOutput("no_frame_after_reset", frameCount - fc0, 0);
        checkOutput("tx_idle_after_reset", {63'b0, tx}, 64'd1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
